// File: rtl/sensor_frame_sched.sv
// Two-channel sensor sample scheduler: round-robin picks a sample and streams it
// to a byte UART as HEADER, ID, data[15:8], data[7:0], CHK with a per-byte timeout.
module sensor_frame_sched #(
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s0_valid,
  input  logic [15:0] s0_data,
  output logic        s0_ready,
  input  logic        s1_valid,
  input  logic [15:0] s1_data,
  output logic        s1_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic        frame_busy,
  output logic        frame_sent,
  output logic        frame_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, WAIT_DONE} state_e;

  state_e           state_q, state_d;
  logic             last1_q, last1_d;
  logic             ch_q, ch_d;
  logic [15:0]      data_q, data_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             frame_sent_q, frame_sent_d;
  logic             frame_err_q, frame_err_d;
  logic             can_accept, grant1;

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic ch,
                                            input logic [15:0] d);
    logic [7:0] id;
    id = {7'd0, ch};
    case (idx)
      3'd0:    return HEADER;
      3'd1:    return id;
      3'd2:    return d[15:8];
      3'd3:    return d[7:0];
      default: return id ^ d[15:8] ^ d[7:0];
    endcase
  endfunction

  // The frame_sent cycle is held off so a new sample is taken only the cycle after it.
  assign can_accept = rst_n && (state_q == IDLE) && !tx_busy && !frame_sent_q;
  assign grant1     = s1_valid && (!s0_valid || !last1_q);
  assign s0_ready   = can_accept && s0_valid && !grant1;
  assign s1_ready   = can_accept && s1_valid && grant1;

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign frame_busy = (state_q != IDLE);
  assign frame_sent = frame_sent_q;
  assign frame_err  = frame_err_q;

  always_comb begin
    state_d      = state_q;
    last1_d      = last1_q;
    ch_d         = ch_q;
    data_d       = data_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    frame_sent_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s0_ready || s1_ready) begin
          ch_d       = s1_ready;
          data_d     = s1_ready ? s1_data : s0_data;
          idx_d      = 3'd0;
          cnt_d      = '0;
          tx_start_d = 1'b1;
          tx_data_d  = HEADER;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // tx_done takes priority over a timeout landing in the same cycle.
        if (tx_done) begin
          cnt_d = '0;
          if (idx_q == 3'd4) begin
            state_d      = IDLE;
            idx_d        = 3'd0;
            frame_sent_d = 1'b1;
            last1_d      = ch_q;
          end else begin
            idx_d      = idx_q + 3'd1;
            tx_start_d = 1'b1;
            tx_data_d  = frame_byte(idx_q + 3'd1, ch_q, data_q);
          end
        end else if (cnt_q == CNT_MAX) begin
          state_d     = IDLE;
          idx_d       = 3'd0;
          cnt_d       = '0;
          frame_err_d = 1'b1;
          last1_d     = ch_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last1_q      <= 1'b1;
      ch_q         <= 1'b0;
      data_q       <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      frame_sent_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last1_q      <= last1_d;
      ch_q         <= ch_d;
      data_q       <= data_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      frame_sent_q <= frame_sent_d;
      frame_err_q  <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_sensor_frame_sched.sv
// Bench for sensor_frame_sched: directed frames, tie/fairness, timeout, mid-frame reset,
// and a randomized two-channel run checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_sensor_frame_sched;

  logic        clk, rst_n;
  logic        s0_valid, s1_valid, s0_ready, s1_ready;
  logic [15:0] s0_data, s1_data;
  logic        tx_start, tx_busy, tx_done;
  logic [7:0]  tx_data;
  logic        frame_busy, frame_sent, frame_err;

  typedef struct packed { logic ch; logic [15:0] d; } acc_t;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  logic [7:0]  tx_log[$];
  acc_t        acc_log[$];
  int          start_cnt = 0, sent_cnt = 0, err_cnt = 0, viol = 0;
  int          uart_bytes = 0;
  int          uart_limit = 32'h7fff_ffff;
  bit          uart_flush = 1'b0;
  logic        mon_prev_ch;
  bit          mon_prev_start;

  sensor_frame_sched #(.HEADER(8'hA5), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .frame_busy(frame_busy), .frame_sent(frame_sent), .frame_err(frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // UART model: busy from tx_start until a done pulse 1..4 cycles later.
  initial begin
    bit pend;
    int dly;
    pend = 1'b0; dly = 0;
    tx_busy = 1'b0; tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_done = 1'b0;
      if (!rst_n || uart_flush) begin
        tx_busy = 1'b0; pend = 1'b0;
      end else if (tx_start) begin
        tx_busy = 1'b1; pend = 1'b1; dly = $urandom_range(0, 3);
      end else if (pend && uart_bytes < uart_limit) begin
        if (dly == 0) begin
          tx_done = 1'b1; tx_busy = 1'b0; pend = 1'b0; uart_bytes++;
        end else dly--;
      end
    end
  end

  // Passive monitor: logs bytes/handshakes and counts protocol violations.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      mon_prev_ch = 1'b1; mon_prev_start = 1'b0;
    end else begin
      if (tx_start) begin
        tx_log.push_back(tx_data); start_cnt++;
        if (mon_prev_start) viol++;
      end
      mon_prev_start = tx_start;
      if (frame_sent) sent_cnt++;
      if (frame_err) err_cnt++;
      if (s0_ready && s1_ready) viol++;
      if ((s0_ready && !s0_valid) || (s1_ready && !s1_valid)) viol++;
      if ((s0_ready || s1_ready) && (frame_busy || tx_busy || frame_sent)) viol++;
      if (s0_ready || s1_ready) begin
        if (s0_valid && s1_valid && s1_ready == mon_prev_ch) viol++;
        mon_prev_ch = s1_ready;
        acc_log.push_back({s1_ready, s1_ready ? s1_data : s0_data});
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] frame40(input logic ch, input logic [15:0] d);
    logic [7:0] id;
    id = {7'd0, ch};
    return {8'hA5, id, d, id ^ d[15:8] ^ d[7:0]};
  endfunction

  function automatic logic [7:0] logged(input int i);
    if (i < tx_log.size()) return tx_log[i];
    return 8'hxx;
  endfunction

  task automatic check_frame(input string tag, input int base, input int nbytes,
                             input logic [39:0] f);
    for (int k = 0; k < nbytes; k++)
      check(tag, 32'(logged(base + k)), 32'(f[39-8*k -: 8]));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_frame_busy"}, 32'(frame_busy), 32'd0);
    check({tag, "_frame_sent"}, 32'(frame_sent), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_s0_ready"}, 32'(s0_ready), 32'd0);
    check({tag, "_s1_ready"}, 32'(s1_ready), 32'd0);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic offer(input logic ch, input logic [15:0] d);
    int n;
    n = 0;
    if (ch) begin s1_valid = 1'b1; s1_data = d; end
    else begin s0_valid = 1'b1; s0_data = d; end
    do begin @(negedge clk); n++; end while (!(ch ? s1_ready : s0_ready) && n < 200);
    check("accept", 32'(ch ? s1_ready : s0_ready), 32'd1);
    @(posedge clk); #1;
    if (ch) s1_valid = 1'b0; else s0_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!(frame_sent || frame_err) && n < 500);
    check({tag, "_end"}, 32'(frame_sent || frame_err), 32'd1);
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic run_both(input string tag, input logic [15:0] d0, input logic [15:0] d1);
    int   ab, tb0, sb, nsent, n;
    logic r0, r1;
    ab = acc_log.size(); tb0 = tx_log.size(); sb = sent_cnt;
    s0_data = d0; s1_data = d1; s0_valid = 1'b1; s1_valid = 1'b1;
    nsent = 0; n = 0;
    while (nsent < 2 && n < 400) begin
      @(negedge clk); n++;
      r0 = s0_ready; r1 = s1_ready;
      if (frame_sent) nsent++;
      @(posedge clk); #1;
      if (r0) s0_valid = 1'b0;
      if (r1) s1_valid = 1'b0;
    end
    check({tag, "_two_frames"}, 32'(nsent), 32'd2);
    repeat (6) @(posedge clk); #1;
    check({tag, "_accepts"}, 32'(acc_log.size() - ab), 32'd2);
    check({tag, "_sent"}, 32'(sent_cnt - sb), 32'd2);
    check({tag, "_first_ch"}, 32'(acc_log.size() > ab ? acc_log[ab].ch : 1'bx), 32'd0);
    check({tag, "_second_ch"}, 32'(acc_log.size() > ab + 1 ? acc_log[ab+1].ch : 1'bx), 32'd1);
    check_frame({tag, "_f0"}, tb0, 5, frame40(1'b0, d0));
    check_frame({tag, "_f1"}, tb0 + 5, 5, frame40(1'b1, d1));
  endtask

  initial begin
    int          tb0, sb, eb, stb, ab, n, nst, bad, i0, i1, j0, j1;
    int unsigned k, ce;
    logic        r0, r1;
    logic [15:0] rq0[20], rq1[20];

    rst_n = 1'b0; s0_valid = 1'b1; s1_valid = 1'b1; s0_data = 16'hFFFF; s1_data = 16'hFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    s0_valid = 1'b0; s1_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    // Single channel 0 and channel 1 frames
    tb0 = tx_log.size(); sb = sent_cnt; stb = start_cnt; eb = err_cnt;
    offer(1'b0, 16'h1234);
    wait_end("ch0");
    check_frame("ch0_byte", tb0, 5, 40'hA5_00_12_34_26);
    check("ch0_starts", 32'(start_cnt - stb), 32'd5);
    check("ch0_sent", 32'(sent_cnt - sb), 32'd1);
    check("ch0_err", 32'(err_cnt - eb), 32'd0);

    tb0 = tx_log.size(); sb = sent_cnt; stb = start_cnt;
    offer(1'b1, 16'hBEEF);
    wait_end("ch1");
    check_frame("ch1_byte", tb0, 5, 40'hA5_01_BE_EF_50);
    check("ch1_starts", 32'(start_cnt - stb), 32'd5);
    check("ch1_sent", 32'(sent_cnt - sb), 32'd1);

    // Tie straight out of reset: channel 0 first
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    run_both("tie_reset", 16'hC3A0, 16'h0F55);

    // s0 held valid across a frame: next ready only the cycle after frame_sent
    tb0 = tx_log.size();
    offer(1'b0, 16'h0001);
    s0_valid = 1'b1; s0_data = 16'h0002;
    bad = 0; n = 0;
    do begin @(negedge clk); n++; if (s0_ready) bad++; end while (!frame_sent && n < 500);
    check("held_ready_low", 32'(bad), 32'd0);
    @(negedge clk);
    check("ready_after_sent", 32'(s0_ready), 32'd1);
    @(posedge clk); #1;
    s0_valid = 1'b0;
    wait_end("held_second");
    check_frame("held_f0", tb0, 5, frame40(1'b0, 16'h0001));
    check_frame("held_f1", tb0 + 5, 5, frame40(1'b0, 16'h0002));

    // Timeout: UART stops answering after two bytes
    tb0 = tx_log.size(); sb = sent_cnt; eb = err_cnt;
    uart_limit = uart_bytes + 2;
    offer(1'b1, 16'h7E81);
    nst = 0; n = 0; k = 0;
    do begin
      @(negedge clk); n++;
      if (tx_start) begin nst++; k = cyc; end
    end while (nst < 3 && n < 500);
    check("timeout_third_start", 32'(nst), 32'd3);
    n = 0;
    do begin @(negedge clk); n++; end while (!(frame_err || frame_sent) && n < 100);
    ce = cyc;
    check("timeout_err_pulse", 32'(frame_err), 32'd1);
    check("timeout_no_sent", 32'(frame_sent), 32'd0);
    check("timeout_cycle", 32'(ce - k), 32'd16);
    check("timeout_idle", 32'(frame_busy), 32'd0);
    @(negedge clk);
    check("timeout_err_one_cycle", 32'(frame_err), 32'd0);
    @(posedge clk); #1;
    uart_flush = 1'b1; uart_limit = 32'h7fff_ffff;
    repeat (2) @(posedge clk); #1;
    uart_flush = 1'b0;
    check("timeout_sent_total", 32'(sent_cnt - sb), 32'd0);
    check("timeout_err_total", 32'(err_cnt - eb), 32'd1);
    check("timeout_bytes", 32'(tx_log.size() - tb0), 32'd3);
    check_frame("timeout_byte", tb0, 3, frame40(1'b1, 16'h7E81));
    run_both("tie_after_timeout", 16'h5501, 16'hAA02);

    // Reset during byte 3
    sb = sent_cnt; eb = err_cnt;
    offer(1'b1, 16'h3C3C);
    nst = 0; n = 0;
    do begin @(negedge clk); n++; if (tx_start) nst++; end while (nst < 3 && n < 500);
    check("midreset_third_start", 32'(nst), 32'd3);
    rst_n = 1'b0; s0_valid = 1'b1; s1_valid = 1'b1;
    #1;
    check_zero("midreset_now");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("midreset_held");
    @(posedge clk); #1;
    s0_valid = 1'b0; s1_valid = 1'b0;
    check("midreset_no_sent", 32'(sent_cnt - sb), 32'd0);
    check("midreset_no_err", 32'(err_cnt - eb), 32'd0);
    rst_n = 1'b1;
    run_both("after_midreset", 16'h9001, 16'h9002);

    // Randomized two-channel traffic
    for (int i = 0; i < 20; i++) begin
      rq0[i] = 16'($urandom); rq1[i] = 16'($urandom);
    end
    ab = acc_log.size(); tb0 = tx_log.size(); sb = sent_cnt; eb = err_cnt;
    i0 = 0; i1 = 0; n = 0;
    while ((i0 < 20 || i1 < 20) && n < 20000) begin
      @(negedge clk); n++;
      r0 = s0_ready; r1 = s1_ready;
      @(posedge clk); #1;
      if (r0) begin i0++; s0_valid = 1'b0; end
      if (r1) begin i1++; s1_valid = 1'b0; end
      if (!s0_valid && i0 < 20 && $urandom_range(0, 2) == 0) begin
        s0_valid = 1'b1; s0_data = rq0[i0];
      end
      if (!s1_valid && i1 < 20 && $urandom_range(0, 2) == 0) begin
        s1_valid = 1'b1; s1_data = rq1[i1];
      end
    end
    n = 0;
    do begin @(negedge clk); n++; end while (frame_busy && n < 500);
    repeat (3) @(posedge clk); #1;
    check("rnd_accepts", 32'(acc_log.size() - ab), 32'd40);
    check("rnd_sent", 32'(sent_cnt - sb), 32'd40);
    check("rnd_err", 32'(err_cnt - eb), 32'd0);
    j0 = 0; j1 = 0;
    for (int i = ab; i < acc_log.size(); i++) begin
      if (acc_log[i].ch == 1'b0) begin
        check("rnd_ch0_seq", 32'(acc_log[i].d), 32'(j0 < 20 ? rq0[j0] : 16'hxxxx));
        j0++;
      end else begin
        check("rnd_ch1_seq", 32'(acc_log[i].d), 32'(j1 < 20 ? rq1[j1] : 16'hxxxx));
        j1++;
      end
      check_frame("rnd_byte", tb0 + 5 * (i - ab), 5, frame40(acc_log[i].ch, acc_log[i].d));
    end

    check("protocol_violations", 32'(viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sensor_frame_sched.md
SENSOR_FRAME_SCHED -- requirements
Module: sensor_frame_sched

Interface
REQ-001 SHALL have parameter HEADER, default 8'hA5, first byte of every frame.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 200000, maximum clocks to wait for tx_done per byte.
REQ-003 SHALL have ports, in order:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- s0_valid  input  1  channel 0 sample available
- s0_data  input  16  channel 0 sample
- s0_ready  output  1  channel 0 sample accepted this cycle
- s1_valid  input  1  channel 1 sample available
- s1_data  input  16  channel 1 sample
- s1_ready  output  1  channel 1 sample accepted this cycle
- tx_start  output  1  one-cycle start pulse to the UART transmitter
- tx_data  output  8  byte to transmit, valid while tx_start is high
- tx_busy  input  1  UART transmitter busy
- tx_done  input  1  UART one-cycle byte-complete pulse
- frame_busy  output  1  frame in progress
- frame_sent  output  1  one-cycle pulse, frame completed
- frame_err  output  1  one-cycle pulse, frame aborted on timeout
REQ-004 SHALL use a single clock; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-005 SHALL transmit each accepted sample as a 5-byte frame: HEADER, ID, data[15:8], data[7:0], CHK.
REQ-006 ID SHALL be 8'h00 for channel 0 and 8'h01 for channel 1; CHK SHALL be ID ^ data[15:8] ^ data[7:0].
REQ-007 SHALL have states IDLE and WAIT_DONE; frame_busy SHALL be high exactly when the state is not IDLE.
REQ-008 In IDLE with tx_busy low, the block SHALL grant one channel per cycle: the only valid channel, or, when both are valid, the channel not granted last.
REQ-009 The round-robin pointer SHALL reset to "last granted = channel 1", so channel 0 wins the first tie.
REQ-010 sN_ready SHALL be combinational and high only when in IDLE, tx_busy is low, sN_valid is high and channel N is granted.
REQ-011 At most one ready SHALL be high per cycle.
REQ-012 On acceptance, the block SHALL latch the channel and data.
REQ-013 On the acceptance edge, the block SHALL register tx_start=1 and tx_data=HEADER, and move to WAIT_DONE.
REQ-014 tx_start SHALL be high for exactly one clock per byte.
REQ-015 tx_data SHALL hold its value until the next byte is loaded.
REQ-016 In WAIT_DONE, on tx_done, the block SHALL advance the byte index.
REQ-017 If bytes remain, the block SHALL register tx_start=1 with the next byte on the same edge, giving a 1-clock gap after each tx_done.
REQ-018 On tx_done for byte 5 (CHK), the block SHALL return to IDLE, pulse frame_sent for one cycle, and update the round-robin pointer.
REQ-019 A new sample SHALL be acceptable in the cycle after frame_sent.
REQ-020 A per-byte timeout counter SHALL clear on each tx_start and increment every WAIT_DONE cycle.
REQ-021 When the counter reaches TIMEOUT_CYCLES-1 without tx_done, the block SHALL abort to IDLE and pulse frame_err for one cycle, with no frame_sent.
REQ-022 On a timeout abort, the round-robin pointer SHALL still update.
REQ-023 tx_done arriving in the same cycle as the timeout SHALL win: normal advance, no error.
REQ-024 tx_done received in IDLE SHALL be ignored.
REQ-025 Valid inputs that are not granted SHALL be held off by ready low; no sample SHALL be dropped or duplicated.

Reset
REQ-026 While rst_n is low, the following SHALL be 0: tx_start, tx_data, frame_busy, frame_sent, frame_err, s0_ready and s1_ready.
REQ-027 While rst_n is low, the byte index and timeout counter SHALL be 0, the state SHALL be IDLE, and the pointer SHALL be "last = channel 1".
REQ-028 Reset asserted mid-frame SHALL abandon the frame immediately, with no frame_sent and no frame_err.
REQ-029 After reset releases, the first tie SHALL go to channel 0.

Verification
REQ-030 Channel 0 sample 0x1234, model UART responding with done: the bench SHALL check the tx_data bytes A5,00,12,34,26, five tx_start pulses, and frame_sent once.
REQ-031 Channel 1 sample 0xBEEF: the bench SHALL check bytes A5,01,BE,EF,50.
REQ-032 s0_valid and s1_valid both high from the first cycle after reset: the bench SHALL check that the channel 0 frame is sent first, then the channel 1 frame, with no extra frames.
REQ-033 s0_valid held high during a frame: the bench SHALL check that s0_ready stays low until the cycle after frame_sent.
REQ-034 TIMEOUT_CYCLES=16 with tx_done withheld after byte 2: the bench SHALL check frame_err one cycle after 16 WAIT_DONE cycles, then IDLE, and no frame_sent.
REQ-035 rst_n pulsed low during byte 3: the bench SHALL check all outputs 0 while reset is low, then that the next frame starts with A5 for channel 0.
